mgmt_gpio_blink_monitor: RTL and testbench

MGMT_GPIO_BLINK_MONITOR -- requirements
Module: mgmt_gpio_blink_monitor

---
 rtl/mgmt_gpio_mon_pkg.sv | 23 ++
 rtl/gpio_sync_edge.sv | 33 +++
 rtl/mgmt_gpio_blink_monitor.sv | 144 ++++++++++++++
 tb/tb_mgmt_gpio_blink_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_gpio_mon_pkg.sv
// Shared types and constants for the management GPIO blink monitor.
//   state_e      : monitor FSM states
//   FAIL_*       : fail_code encodings
//   sat_inc16()  : 16-bit saturating increment used by the high-phase width counter
package mgmt_gpio_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitHigh,
    StWaitLow,
    StPass,
    StFail
  } state_e;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b01;
  localparam logic [1:0] FAIL_GLITCH  = 2'b10;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer plus history flop for an asynchronous GPIO level, with
// single-cycle rise/fall strobes derived from the synchronized level.
//   core_clk : clock
//   core_rst : synchronous active-high reset, clears all three flops
//   gpio_in  : asynchronous level
//   rise     : high for one cycle after a synchronized low-to-high change
//   fall     : high for one cycle after a synchronized high-to-low change
module gpio_sync_edge (
  input  logic core_clk,
  input  logic core_rst,
  input  logic gpio_in,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= gpio_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/mgmt_gpio_blink_monitor.sv
// Counts complete high-then-low blinks on the management GPIO after an arm
// request and reports pass once BLINK_TARGET good blinks are seen, or fail on a
// too-short high phase (glitch) or on too long a gap between edges (timeout).
//   core_clk        : clock
//   core_rst        : synchronous active-high reset
//   gpio_in         : asynchronous GPIO level under observation
//   start           : single-cycle arm request (honoured in idle/pass/fail only)
//   done            : high in pass or fail
//   pass            : high in pass only
//   fail_code       : 00 none, 01 timeout, 10 glitch
//   blink_count     : completed blinks since last arm
//   last_high_width : width of the most recent good high phase, saturating
module mgmt_gpio_blink_monitor
  import mgmt_gpio_mon_pkg::*;
#(
  parameter int unsigned BLINK_TARGET   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned MIN_PULSE      = 4
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        gpio_in,
  input  logic        start,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [7:0]  blink_count,
  output logic [15:0] last_high_width
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value just before terminal count: the increment that would reach
  // TIMEOUT_CYCLES is replaced by the transition to fail.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      Target  = 8'(BLINK_TARGET);

  logic rise, fall;

  gpio_sync_edge u_sync (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .gpio_in  (gpio_in),
    .rise     (rise),
    .fall     (fall)
  );

  state_e          state_q, state_d;
  logic [7:0]      blink_q, blink_d;
  logic [15:0]     last_q, last_d;
  logic [15:0]     width_q, width_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [1:0]      fail_q, fail_d;

  logic [15:0] width_inc;
  logic [7:0]  blink_inc;
  logic        tmo_hit;

  always_comb begin
    state_d   = state_q;
    blink_d   = blink_q;
    last_d    = last_q;
    width_d   = width_q;
    tmo_d     = tmo_q;
    fail_d    = fail_q;
    // Width includes the cycle in which the fall is seen, so it equals the
    // number of cycles the synchronized level was high.
    width_inc = sat_inc16(width_q);
    blink_inc = blink_q + 8'd1;
    tmo_hit   = (tmo_q == TmoLast);

    unique case (state_q)
      StIdle, StPass, StFail: begin
        if (start) begin
          state_d = StWaitHigh;
          blink_d = 8'd0;
          last_d  = 16'd0;
          width_d = 16'd0;
          tmo_d   = '0;
          fail_d  = FAIL_NONE;
        end
      end
      StWaitHigh: begin
        // A fall here (level high at arm) only restarts the timer.
        if (rise || fall) begin
          tmo_d = '0;
          if (rise) begin
            state_d = StWaitLow;
            width_d = 16'd0;
          end
        end else if (tmo_hit) begin
          state_d = StFail;
          fail_d  = FAIL_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWaitLow: begin
        width_d = width_inc;
        if (fall) begin
          tmo_d = '0;
          if ({16'd0, width_inc} < MIN_PULSE) begin
            state_d = StFail;
            fail_d  = FAIL_GLITCH;
          end else begin
            blink_d = blink_inc;
            last_d  = width_inc;
            state_d = (blink_inc == Target) ? StPass : StWaitHigh;
          end
        end else if (tmo_hit) begin
          state_d = StFail;
          fail_d  = FAIL_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q <= StIdle;
      blink_q <= 8'd0;
      last_q  <= 16'd0;
      width_q <= 16'd0;
      tmo_q   <= '0;
      fail_q  <= FAIL_NONE;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      last_q  <= last_d;
      width_q <= width_d;
      tmo_q   <= tmo_d;
      fail_q  <= fail_d;
    end
  end

  assign done            = (state_q == StPass) || (state_q == StFail);
  assign pass            = (state_q == StPass);
  assign fail_code       = fail_q;
  assign blink_count     = blink_q;
  assign last_high_width = last_q;

endmodule

// File: tb/tb_mgmt_gpio_blink_monitor.sv
// Scoreboard bench: each run's GPIO event list is evaluated by an event-level
// reference model whose predicted outcome is queued; a monitor pops and
// compares when done rises.
module tb_mgmt_gpio_blink_monitor;
  import mgmt_gpio_mon_pkg::*;

  localparam int TGT  = 10;
  localparam int TMO  = 200;
  localparam int MINP = 4;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        gpio_in;
  logic        start;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [7:0]  blink_count;
  logic [15:0] last_high_width;

  mgmt_gpio_blink_monitor #(
    .BLINK_TARGET   (TGT),
    .TIMEOUT_CYCLES (TMO),
    .MIN_PULSE      (MINP)
  ) dut (
    .core_clk        (core_clk),
    .core_rst        (core_rst),
    .gpio_in         (gpio_in),
    .start           (start),
    .done            (done),
    .pass            (pass),
    .fail_code       (fail_code),
    .blink_count     (blink_count),
    .last_high_width (last_high_width)
  );

  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         pass;
    logic [1:0] code;
    int         cnt;
    int         last;
    int         done_at;
  } exp_t;

  exp_t sb_q[$];
  int   ev_n[$];
  bit   ev_l[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event-level model: edges appear 2 cycles after the negedge a level is driven
  // on; any gap longer than TMO since arm or the last edge times out; a gap of
  // exactly TMO is saved by the edge.
  function automatic exp_t model(input bit init_lvl, input int arm);
    exp_t e;
    int tprev, cnt, last, rise_t, t, w;
    bit lvl, wait_high;
    tprev = 0; cnt = 0; last = 0; rise_t = 0; lvl = init_lvl; wait_high = 1'b1;
    e.pass = 1'b0; e.code = FAIL_TIMEOUT; e.cnt = 0; e.last = 0; e.done_at = 0;
    for (int i = 0; i < ev_n.size(); i++) begin
      t = ev_n[i] + 2;
      if (ev_l[i] == lvl) continue;
      if (t - tprev > TMO) begin
        e.cnt = cnt; e.last = last; e.done_at = arm + tprev + TMO;
        return e;
      end
      tprev = t;
      lvl   = ev_l[i];
      if (wait_high) begin
        if (lvl) begin
          wait_high = 1'b0;
          rise_t    = t;
        end
      end else if (!lvl) begin
        w = t - rise_t;
        if (w < MINP) begin
          e.code = FAIL_GLITCH; e.cnt = cnt; e.last = last; e.done_at = arm + t;
          return e;
        end
        cnt++;
        last = w;
        if (cnt == TGT) begin
          e.pass = 1'b1; e.code = FAIL_NONE; e.cnt = cnt; e.last = last; e.done_at = arm + t;
          return e;
        end
        wait_high = 1'b1;
      end
    end
    e.cnt = cnt; e.last = last; e.done_at = arm + tprev + TMO;
    return e;
  endfunction

  exp_t mon_e;
  logic done_prev = 1'b0;

  always @(negedge core_clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pass", {31'd0, pass}, {31'd0, mon_e.pass});
        check("fail_code", {30'd0, fail_code}, {30'd0, mon_e.code});
        check("blink_count", {24'd0, blink_count}, mon_e.cnt);
        check("last_high_width", {16'd0, last_high_width}, mon_e.last);
        check("done_cycle", cyc, mon_e.done_at);
      end
    end
    done_prev = done;
  end

  task automatic clear_ev();
    ev_n.delete();
    ev_l.delete();
  endtask

  task automatic push_ev(input int n, input bit l);
    ev_n.push_back(n);
    ev_l.push_back(l);
  endtask

  function automatic int add_blinks(input int first, input int nb, input int hi, input int lo);
    int n;
    n = first;
    for (int i = 0; i < nb; i++) begin
      ev_n.push_back(n);     ev_l.push_back(1'b1);
      ev_n.push_back(n + hi); ev_l.push_back(1'b0);
      n = n + hi + lo;
    end
    return n;
  endfunction

  // One armed run: predict, queue, then drive start and the event list.
  task automatic run(input bit stray_start);
    exp_t e;
    int arm, idx, x;
    @(negedge core_clk);
    arm = cyc + 1;
    e   = model(gpio_in, arm);
    x   = e.done_at - arm;
    sb_q.push_back(e);
    start = 1'b1;
    idx   = 0;
    for (int n = 0; n <= x + 4; n++) begin
      if (n > 0) begin
        @(negedge core_clk);
        start = stray_start && (n == x / 2);
      end
      while (idx < ev_n.size() && ev_n[idx] == n) begin
        if (n <= x) gpio_in = ev_l[idx];
        idx++;
      end
    end
    start = 1'b0;
  endtask

  task automatic settle_gpio(input bit l);
    gpio_in = l;
    repeat (5) @(negedge core_clk);
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge core_clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d, r;
    bit lvl;
    core_rst = 1'b1;
    start    = 1'b0;
    gpio_in  = 1'b0;
    wait_cycles(3);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_fail_code", {30'd0, fail_code}, 32'd0);
    check("rst_blink_count", {24'd0, blink_count}, 32'd0);
    check("rst_last_width", {16'd0, last_high_width}, 32'd0);
    core_rst = 1'b0;
    gpio_in  = 1'b1;
    wait_cycles(6);
    gpio_in  = 1'b0;
    wait_cycles(6);
    check("idle_without_start", {31'd0, done}, 32'd0);
    check("idle_state", {31'd0, dut.state_q == StIdle}, 32'd1);

    // Nominal, then re-arm from pass.
    clear_ev(); n = add_blinks(10, 10, 50, 50);
    run(1'b0);
    run(1'b1);

    // Glitch after three good blinks.
    clear_ev(); n = add_blinks(10, 3, 50, 50);
    push_ev(n, 1'b1); push_ev(n + 2, 1'b0);
    run(1'b0);

    // Timeout with gpio held low.
    settle_gpio(1'b0);
    clear_ev();
    run(1'b0);

    // Level high at arm, falls 30 cycles later, then blinks.
    settle_gpio(1'b1);
    clear_ev(); push_ev(30, 1'b0); n = add_blinks(40, 10, 10, 10);
    run(1'b0);

    // Edge/terminal-count ties: first rise and a high phase both exactly TMO.
    settle_gpio(1'b0);
    clear_ev(); n = add_blinks(TMO - 2, 1, TMO, 10); n = add_blinks(n, 9, 6, 6);
    run(1'b0);

    // Reset in the middle of a high phase after five blinks.
    settle_gpio(1'b0);
    @(negedge core_clk); start = 1'b1;
    @(negedge core_clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gpio_in = 1'b1; wait_cycles(20);
      gpio_in = 1'b0; wait_cycles(20);
    end
    gpio_in = 1'b1; wait_cycles(10);
    check("midrun_count", {24'd0, blink_count}, 32'd5);
    check("midrun_width", {16'd0, last_high_width}, 32'd20);
    core_rst = 1'b1;
    @(negedge core_clk); core_rst = 1'b0;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_pass", {31'd0, pass}, 32'd0);
    check("midrst_fail_code", {30'd0, fail_code}, 32'd0);
    check("midrst_blink_count", {24'd0, blink_count}, 32'd0);
    check("midrst_last_width", {16'd0, last_high_width}, 32'd0);
    check("midrst_state", {31'd0, dut.state_q == StIdle}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      gpio_in = 1'b0; wait_cycles(8);
      gpio_in = 1'b1; wait_cycles(8);
    end
    gpio_in = 1'b0; wait_cycles(8);
    check("post_rst_count", {24'd0, blink_count}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);

    // Randomized runs.
    for (int k = 0; k < 15; k++) begin
      clear_ev();
      lvl = gpio_in;
      n   = $urandom_range(1, 20);
      for (int i = 0; i < 24; i++) begin
        lvl = !lvl;
        push_ev(n, lvl);
        r = $urandom_range(0, 15);
        if (r == 0) d = $urandom_range(TMO - 5, TMO + 5);
        else if (r == 1 && lvl) d = $urandom_range(1, 3);
        else d = $urandom_range(4, 30);
        n = n + d;
      end
      run(bit'($urandom_range(0, 1)));
    end

    wait_cycles(5);
    while (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check("done_never_seen", 32'd0, mon_e.done_at);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
